// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg
// Shared types and constants for the hex display arbiter.
//   disp_state_e : arbiter FSM states. The SHOW encodings equal the owner codes.
//   OWNER_*      : codes driven on disp_owner.
//   owner_of()   : maps an FSM state to the owner code it displays.
package hex_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHOW_A = 2'b01,
    SHOW_B = 2'b10
  } disp_state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  // Owner code shown while the FSM sits in a given state.
  function automatic logic [1:0] owner_of(input disp_state_e st);
    logic [1:0] owner;
    case (st)
      SHOW_A:  owner = OWNER_A;
      SHOW_B:  owner = OWNER_B;
      default: owner = OWNER_NONE;
    endcase
    return owner;
  endfunction

endpackage

// File: rtl/hex_disp_if.sv
// hex_disp_if
// Bus between the two display requesters and the arbiter.
//   req_a/req_b     : ownership requests (requester -> arbiter)
//   data_a/data_b   : eight 4-bit digits each, bits [3:0] = digit 0
//   gnt_a/gnt_b     : registered grants (arbiter -> requesters)
//   disp_val        : digit nibbles for the 7-segment decoders
//   disp_owner      : 00 none, 01 A, 10 B
//   disp_valid      : high while a requester owns the display
// Modports: master = requester side, slave = arbiter side.
interface hex_disp_if;

  logic        req_a;
  logic        req_b;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        gnt_a;
  logic        gnt_b;
  logic [31:0] disp_val;
  logic [1:0]  disp_owner;
  logic        disp_valid;

  modport master (
    output req_a, req_b, data_a, data_b,
    input  gnt_a, gnt_b, disp_val, disp_owner, disp_valid
  );

  modport slave (
    input  req_a, req_b, data_a, data_b,
    output gnt_a, gnt_b, disp_val, disp_owner, disp_valid
  );

endinterface

// File: rtl/hex_disp_key_debounce.sv
// key_debounce
// Turns the asynchronous, active-low push key into a single-cycle pulse.
//   CLOCK_50   : system clock
//   RESET_N    : asynchronous reset, active low (key state "released")
//   step_n     : raw push key, active low, asynchronous
//   step_pulse : one-cycle pulse on each accepted press
// Optional feature macro HEX_DISP_DEBOUNCE_EN: when defined, the synchronized
// key level must stay unchanged for DEBOUNCE_CYCLES cycles before it is
// accepted. Without the macro only the 2-FF synchronizer precedes the edge
// detector.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic step_n,
  output logic step_pulse
);

  logic sync1_r;
  logic sync2_r;
  logic level_s;
  logic level_d_r;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= step_n;
      sync2_r <= sync1_r;
    end
  end

`ifdef HEX_DISP_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] stable_cnt_r;
  logic             stable_r;

  // Stability filter: a new level is taken only after it has differed from
  // the accepted level for DEBOUNCE_CYCLES consecutive cycles; any bounce
  // back to the accepted level restarts the count.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      stable_cnt_r <= '0;
      stable_r     <= 1'b1;
    end else if (sync2_r != stable_r) begin
      if (stable_cnt_r == CNT_LAST) begin
        stable_r     <= sync2_r;
        stable_cnt_r <= '0;
      end else begin
        stable_cnt_r <= stable_cnt_r + 1'b1;
      end
    end else begin
      stable_cnt_r <= '0;
    end
  end

  assign level_s = stable_r;
`else
  assign level_s = sync2_r;
`endif

  // Previous accepted level, for falling-edge detection.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      level_d_r <= 1'b1;
    end else begin
      level_d_r <= level_s;
    end
  end

  // High for exactly the one cycle after the level goes 1 -> 0; holding the
  // key keeps level_s low and produces nothing further.
  assign step_pulse = level_d_r & ~level_s;

endmodule

// File: rtl/hex_disp_arbiter.sv
// hex_disp_arbiter
// Arbitrates ownership of an eight-digit hex display between two requesters.
// A granted side keeps the display for at least HOLD_CYCLES cycles unless it
// drops its request; a step key press forces an early rotation.
//   CLOCK_50 : system clock, rising edge
//   RESET_N  : asynchronous reset, active low
//   step_n   : push key, active low, asynchronous
//   bus      : hex_disp_if.slave (requests, digit data, grants, display)
// Parameters: HOLD_CYCLES (minimum ownership), DEBOUNCE_CYCLES (key filter).
// Optional feature macro HEX_DISP_DEBOUNCE_EN enables the key stability filter.
module hex_disp_arbiter
  import hex_disp_pkg::*;
#(
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       step_n,
  hex_disp_if.slave  bus
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  disp_state_e       state_r;
  disp_state_e       next_state_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [1:0]        last_owner_r;
  logic              step_pulse_s;
  logic              expire_s;
  logic              restart_s;
  logic              entry_s;

  logic              gnt_a_r;
  logic              gnt_b_r;
  logic [31:0]       disp_val_r;
  logic [1:0]        disp_owner_r;
  logic              disp_valid_r;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .step_n     (step_n),
    .step_pulse (step_pulse_s)
  );

  // A step pulse is folded into the expiry term, so a pulse landing on the
  // natural expiry cycle still yields only one rotation decision.
  assign expire_s = (hold_cnt_r == HOLD_LAST) || step_pulse_s;

  // Next-state logic; restart_s marks re-entry of the same SHOW state.
  always_comb begin
    next_state_s = state_r;
    restart_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          next_state_s = (last_owner_r == OWNER_A) ? SHOW_B : SHOW_A;
        end else if (bus.req_a) begin
          next_state_s = SHOW_A;
        end else if (bus.req_b) begin
          next_state_s = SHOW_B;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHOW_A: begin
        if (!bus.req_a) begin
          next_state_s = bus.req_b ? SHOW_B : IDLE;
        end else if (expire_s) begin
          if (bus.req_b) begin
            next_state_s = SHOW_B;
          end else begin
            next_state_s = SHOW_A;
            restart_s    = 1'b1;
          end
        end else begin
          next_state_s = SHOW_A;
        end
      end
      SHOW_B: begin
        if (!bus.req_b) begin
          next_state_s = bus.req_a ? SHOW_A : IDLE;
        end else if (expire_s) begin
          if (bus.req_a) begin
            next_state_s = SHOW_A;
          end else begin
            next_state_s = SHOW_B;
            restart_s    = 1'b1;
          end
        end else begin
          next_state_s = SHOW_B;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  assign entry_s = ((next_state_s != state_r) || restart_s) && (next_state_s != IDLE);

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Hold counter: zero on every SHOW entry (including restart) and in IDLE.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_cnt_r <= '0;
    end else if (entry_s || (next_state_s == IDLE)) begin
      hold_cnt_r <= '0;
    end else begin
      hold_cnt_r <= hold_cnt_r + 1'b1;
    end
  end

  // Last owner, used to break ties in IDLE; starts as B so A wins first.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      last_owner_r <= OWNER_B;
    end else if (entry_s) begin
      last_owner_r <= owner_of(next_state_s);
    end else begin
      last_owner_r <= last_owner_r;
    end
  end

  // Moore outputs, registered from the next state so they track state_r.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      gnt_a_r      <= 1'b0;
      gnt_b_r      <= 1'b0;
      disp_owner_r <= OWNER_NONE;
      disp_valid_r <= 1'b0;
    end else begin
      gnt_a_r      <= (next_state_s == SHOW_A);
      gnt_b_r      <= (next_state_s == SHOW_B);
      disp_owner_r <= owner_of(next_state_s);
      disp_valid_r <= (next_state_s != IDLE);
    end
  end

  // Display data follows the owner's digits one cycle late; IDLE keeps the
  // last shown value.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      disp_val_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        SHOW_A:  disp_val_r <= bus.data_a;
        SHOW_B:  disp_val_r <= bus.data_b;
        default: disp_val_r <= disp_val_r;
      endcase
    end
  end

  assign bus.gnt_a      = gnt_a_r;
  assign bus.gnt_b      = gnt_b_r;
  assign bus.disp_val   = disp_val_r;
  assign bus.disp_owner = disp_owner_r;
  assign bus.disp_valid = disp_valid_r;

endmodule

// File: tb/tb_hex_disp_arbiter.sv
// tb_hex_disp_arbiter
// Directed bench for hex_disp_arbiter with HOLD_CYCLES=8, DEBOUNCE_CYCLES=4.
module tb_hex_disp_arbiter;

  localparam int HOLD = 8;
  localparam int DEB  = 4;

  // Edges from driving step_n low (just after an edge) to the FSM acting on
  // the pulse: 2 synchronizer edges, DEB filter edges, then the pulse cycle.
`ifdef HEX_DISP_DEBOUNCE_EN
  localparam int STEP_LAT = 2 + DEB + 1;
`else
  localparam int STEP_LAT = 3;
`endif

  logic CLOCK_50;
  logic RESET_N;
  logic step_n;

  int n_vec;
  int n_miss;
  int cyc;
  int rel_at;

  hex_disp_if bus_if ();

  hex_disp_arbiter #(
    .HOLD_CYCLES     (HOLD),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .step_n   (step_n),
    .bus      (bus_if.slave)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock, settle, release a held key when due, and confirm the
  // grants are never both high.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    cyc++;
    if (cyc == rel_at) step_n = 1'b1;
    check_val("gnt_excl", {31'd0, bus_if.gnt_a & bus_if.gnt_b}, 32'd0);
  endtask

  task automatic press_key();
    step_n = 1'b0;
    rel_at = cyc + 10;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    cyc    = 0;
    rel_at = -1;
    RESET_N = 1'b0;
    step_n  = 1'b1;
    bus_if.req_a  = 1'b0;
    bus_if.req_b  = 1'b0;
    bus_if.data_a = 32'h0000_0000;
    bus_if.data_b = 32'h0000_0000;

    // Reset state
    tick();
    tick();
    check_val("rst_gnt_a", {31'd0, bus_if.gnt_a}, 32'd0);
    check_val("rst_gnt_b", {31'd0, bus_if.gnt_b}, 32'd0);
    check_val("rst_val", bus_if.disp_val, 32'h0000_0000);
    check_val("rst_owner", {30'd0, bus_if.disp_owner}, 32'd0);
    check_val("rst_valid", {31'd0, bus_if.disp_valid}, 32'd0);
    RESET_N = 1'b1;
    tick();
    check_val("idle_valid", {31'd0, bus_if.disp_valid}, 32'd0);

    // Single request from IDLE, then early drop at hold cycle 3
    bus_if.req_a  = 1'b1;
    bus_if.data_a = 32'h1234_5678;
    tick();
    check_val("a_gnt", {31'd0, bus_if.gnt_a}, 32'd1);
    check_val("a_owner", {30'd0, bus_if.disp_owner}, 32'd1);
    check_val("a_valid", {31'd0, bus_if.disp_valid}, 32'd1);
    check_val("a_val_lat", bus_if.disp_val, 32'h0000_0000);
    tick();
    check_val("a_val", bus_if.disp_val, 32'h1234_5678);
    tick();
    bus_if.req_a = 1'b0;
    tick();
    check_val("drop_gnt", {31'd0, bus_if.gnt_a}, 32'd0);
    check_val("drop_owner", {30'd0, bus_if.disp_owner}, 32'd0);
    check_val("drop_valid", {31'd0, bus_if.disp_valid}, 32'd0);
    bus_if.data_a = 32'hDEAD_BEEF;
    tick();
    check_val("idle_hold_val", bus_if.disp_val, 32'h1234_5678);

    // Both requesting from the cycle after reset release: A, B, A, B every 8
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    bus_if.req_a  = 1'b1;
    bus_if.req_b  = 1'b1;
    bus_if.data_a = 32'h1111_2222;
    bus_if.data_b = 32'hCAFE_F00D;
    for (int i = 1; i <= 32; i++) begin
      tick();
      check_val("alt_owner", {30'd0, bus_if.disp_owner},
                ((((i - 1) / HOLD) % 2) == 0) ? 32'd1 : 32'd2);
      if (i == 2)  check_val("alt_val_a", bus_if.disp_val, 32'h1111_2222);
      if (i == 10) check_val("alt_val_b", bus_if.disp_val, 32'hCAFE_F00D);
    end
    bus_if.req_a = 1'b0;
    bus_if.req_b = 1'b0;
    tick();
    check_val("alt_idle", {30'd0, bus_if.disp_owner}, 32'd0);

    // Glitches ignored, then one long press gives exactly one rotation
    bus_if.req_a = 1'b1;
    tick();
    check_val("g_enter_a", {30'd0, bus_if.disp_owner}, 32'd1);
    bus_if.req_b = 1'b1;
`ifdef HEX_DISP_DEBOUNCE_EN
    step_n = 1'b0;
`endif
    for (int i = 1; i <= 15; i++) begin
      tick();
`ifdef HEX_DISP_DEBOUNCE_EN
      if (i == 2 || i == 6) step_n = 1'b1;
      if (i == 4) step_n = 1'b0;
`endif
      if (i == 14) press_key();
      check_val("g_owner", {30'd0, bus_if.disp_owner}, (i < HOLD) ? 32'd1 : 32'd2);
    end
    // SHOW_A entered at i=16; pulse rotates at 14+STEP_LAT, then B holds 8
    for (int i = 16; i <= 14 + STEP_LAT + HOLD; i++) begin
      tick();
      check_val("p_owner", {30'd0, bus_if.disp_owner},
                (i < 14 + STEP_LAT) ? 32'd1 :
                (i < 14 + STEP_LAT + HOLD) ? 32'd2 : 32'd1);
    end
    bus_if.req_a = 1'b0;
    bus_if.req_b = 1'b0;
    tick();
    check_val("p_idle", {30'd0, bus_if.disp_owner}, 32'd0);
    for (int i = 0; i < 8; i++) tick();

    // Step pulse coincident with expiry: single switch A -> B
    bus_if.req_a = 1'b1;
    tick();
    check_val("x_enter_a", {30'd0, bus_if.disp_owner}, 32'd1);
    bus_if.req_b = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == HOLD - STEP_LAT) press_key();
      check_val("x_owner", {30'd0, bus_if.disp_owner}, (i < HOLD) ? 32'd1 : 32'd2);
    end
    check_val("x_val_b", bus_if.disp_val, 32'hCAFE_F00D);

    // Asynchronous reset mid-SHOW_B, then A wins the first tie
    RESET_N = 1'b0;
    #2;
    check_val("ar_gnt_a", {31'd0, bus_if.gnt_a}, 32'd0);
    check_val("ar_gnt_b", {31'd0, bus_if.gnt_b}, 32'd0);
    check_val("ar_val", bus_if.disp_val, 32'h0000_0000);
    check_val("ar_owner", {30'd0, bus_if.disp_owner}, 32'd0);
    check_val("ar_valid", {31'd0, bus_if.disp_valid}, 32'd0);
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    check_val("ar_regrant_a", {31'd0, bus_if.gnt_a}, 32'd1);
    check_val("ar_regrant_owner", {30'd0, bus_if.disp_owner}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hex_disp_arbiter.md
HEX_DISP_ARBITER -- requirements
Module: hex_disp_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000: minimum CLOCK_50 cycles a granted requester owns the display.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500_000: cycles step_n must be stable before a level is accepted.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLOCK_50  in  1  system clock; all state updates on the rising edge.
REQ-005 RESET_N  in  1  asynchronous reset, active low.
REQ-006 req_a / req_b  in  1 each  display-ownership requests.
REQ-007 data_a / data_b  in  32 each  eight 4-bit digit values; bits [3:0] = digit 0.
REQ-008 step_n  in  1  asynchronous push key, active low; forces rotation.
REQ-009 gnt_a / gnt_b  out  1 each  registered grants.
REQ-010 disp_val  out  32  registered digit nibbles for the 7-segment decoders.
REQ-011 disp_owner  out  2  00 none, 01 A, 10 B; 11 never driven.
REQ-012 disp_valid  out  1  high while a requester owns the display.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHOW_A and SHOW_B.
REQ-014 In IDLE with one request: move to that requester's SHOW state next cycle. With both requests: grant the side opposite last_owner.
REQ-015 gnt_x, disp_owner and disp_valid SHALL be Moore outputs of the SHOW state; gnt_a and gnt_b are never high together.
REQ-016 In SHOW_x, disp_val SHALL load data_x every cycle, with one-cycle latency.
REQ-017 On SHOW entry, hold_cnt SHALL clear and then increment each cycle; expiry = hold_cnt reaching HOLD_CYCLES-1; width $clog2(HOLD_CYCLES+1).
REQ-018 On expiry: go to the other SHOW state if the other side requests. Otherwise, if own req is still high, restart hold in the same state. Otherwise go to IDLE.
REQ-019 If the owner drops req before expiry, the FSM SHALL leave next cycle, to the other SHOW state if requested, else to IDLE.
REQ-020 A step pulse in SHOW_x SHALL act as an immediate expiry, following the REQ-018 rules.
REQ-021 A step pulse in IDLE SHALL be ignored.
REQ-022 A step pulse coincident with expiry SHALL cause exactly one rotation.
REQ-023 last_owner SHALL update on every SHOW entry.
REQ-024 In IDLE, disp_val SHALL hold its last value while disp_valid is 0.
REQ-025 A step pulse SHALL be one cycle wide, generated on the accepted falling edge of step_n; holding the key produces no further pulses.

Reset
REQ-026 While RESET_N is low, the block SHALL hold the following values:
- state IDLE
- gnt_a = gnt_b = 0
- disp_val = 0
- disp_owner = 00
- disp_valid = 0
- hold_cnt = 0
- last_owner = B, so A wins the first tie
- debouncer state "released"
REQ-027 Reset asserted mid-SHOW SHALL clear the outputs asynchronously; the first grant after release follows REQ-014.

Configuration
REQ-028 With macro HEX_DISP_DEBOUNCE_EN defined, step_n SHALL pass through a 2-FF synchronizer and a DEBOUNCE_CYCLES stability filter before edge detection.
REQ-029 Without HEX_DISP_DEBOUNCE_EN, step_n SHALL pass only through the 2-FF synchronizer and edge detector; DEBOUNCE_CYCLES is unused.

Structure
REQ-030 Package hex_disp_pkg SHALL hold the state enum (IDLE/SHOW_A/SHOW_B) and the owner constants OWNER_NONE=2'b00, OWNER_A=2'b01 and OWNER_B=2'b10.
REQ-031 Sub-module key_debounce SHALL contain the synchronizer, the filter under HEX_DISP_DEBOUNCE_EN and the falling-edge pulse generator.
REQ-032 The FSM, hold counter and output registers SHALL live in hex_disp_arbiter.

Verification (bench: HOLD_CYCLES=8, DEBOUNCE_CYCLES=4, macro defined)
REQ-033 req_a=1, data_a=32'h1234_5678 from IDLE -> gnt_a=1, disp_owner=01 after one cycle; disp_val=32'h1234_5678 one cycle later.
REQ-034 req_a=req_b=1 held, both from the cycle after reset release -> A granted first; at exactly 8 cycles of ownership, ownership alternates B, A, B; gnt never both high.
REQ-035 A owns, req_a drops at hold cycle 3 with req_b=0 -> IDLE next cycle; disp_valid=0; disp_val keeps A's last value.
REQ-036 step_n low with 2-cycle glitches, then low for 10 cycles during SHOW_A with req_b=1 -> glitches ignored; one rotation to SHOW_B only.
REQ-037 Step pulse on the expiry cycle with both requesting -> single switch A to B, not back to A.
REQ-038 RESET_N low mid-SHOW_B -> all outputs 0 within the reset assertion, without a clock edge; after release with both requesting -> A granted.
